// File: rtl/counter_down_load_pkg.sv
// Shared constants and types for the loadable down-counter.
// The count source enum names which value each count bit captures on the next edge.
package counter_down_load_pkg;

    localparam int CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        SRC_HOLD   = 2'd0,
        SRC_LOAD   = 2'd1,
        SRC_DEC    = 2'd2,
        SRC_RELOAD = 2'd3
    } cnt_src_e;

endpackage

// File: rtl/counter_down_load_cnt_bit_ff.sv
// Single storage bit with async active-low clear and a hold/load/next mux.
// Load takes priority over next; with neither strobe the bit holds.
module cnt_bit_ff (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic load_val_i,
    input  logic next_i,
    input  logic next_val_i,
    output logic q_o
);

    logic q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (load_i)
            q_d = load_val_i;
        else if (next_i)
            q_d = next_val_i;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q_q <= 1'b0;
        else
            q_q <= q_d;
    end

    assign q_o = q_q;

endmodule

// File: rtl/counter_down_load.sv
// Loadable down-counter / interval timer with terminal count, done and underflow pulses.
// Optional auto-reload turns it into a periodic tick source of period reload+1.
module counter_down_load
    import counter_down_load_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             en_i,
    input  logic             auto_i,
    output logic [WIDTH-1:0] cqo,
    output logic             tc_o,
    output logic             done_o,
    output logic             uf_o
);

    cnt_src_e         src_d;
    logic [WIDTH-1:0] cnt_q, rel_q, cnt_nxt;
    logic             cnt_ld, cnt_nx;
    logic             is_zero, is_one;
    logic             done_q, done_d, uf_q, uf_d;

    assign is_zero = (cnt_q == '0);
    assign is_one  = (cnt_q == WIDTH'(1));

    // At zero without auto-reload the count holds rather than wrapping.
    always_comb begin
        src_d   = SRC_HOLD;
        done_d  = 1'b0;
        uf_d    = 1'b0;
        if (load_i) begin
            src_d = SRC_LOAD;
        end else if (en_i) begin
            if (is_zero) begin
                uf_d = 1'b1;
                if (auto_i)
                    src_d = SRC_RELOAD;
            end else begin
                src_d  = SRC_DEC;
                done_d = is_one;
            end
        end
    end

    always_comb begin
        cnt_nxt = cnt_q - WIDTH'(1);
        if (src_d == SRC_RELOAD)
            cnt_nxt = rel_q;
    end

    assign cnt_ld = (src_d == SRC_LOAD);
    assign cnt_nx = (src_d == SRC_DEC) || (src_d == SRC_RELOAD);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        cnt_bit_ff u_cnt (
            .clk       (clk),
            .reset     (reset),
            .load_i    (cnt_ld),
            .load_val_i(d_i[i]),
            .next_i    (cnt_nx),
            .next_val_i(cnt_nxt[i]),
            .q_o       (cnt_q[i])
        );

        cnt_bit_ff u_rel (
            .clk       (clk),
            .reset     (reset),
            .load_i    (load_i),
            .load_val_i(d_i[i]),
            .next_i    (1'b0),
            .next_val_i(1'b0),
            .q_o       (rel_q[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q <= 1'b0;
            uf_q   <= 1'b0;
        end else begin
            done_q <= done_d;
            uf_q   <= uf_d;
        end
    end

    assign cqo    = cnt_q;
    assign tc_o   = is_zero;
    assign done_o = done_q;
    assign uf_o   = uf_q;

endmodule

// File: tb/tb_counter_down_load.sv
// Bench for counter_down_load: cycle-by-cycle model compare plus directed literal checks.
module tb_counter_down_load;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load_i = 1'b0;
    logic [3:0] d_i = 4'd0;
    logic       en_i = 1'b0;
    logic       auto_i = 1'b0;
    logic [3:0] cqo;
    logic       tc_o, done_o, uf_o;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    logic [3:0] m_cnt, m_rel;
    logic       m_done, m_uf;

    counter_down_load #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .load_i(load_i),
        .d_i   (d_i),
        .en_i  (en_i),
        .auto_i(auto_i),
        .cqo   (cqo),
        .tc_o  (tc_o),
        .done_o(done_o),
        .uf_o  (uf_o)
    );

    always #5 clk = ~clk;

    // Reference behaviour straight from the counting rules.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cnt <= 4'd0; m_rel <= 4'd0; m_done <= 1'b0; m_uf <= 1'b0;
        end else if (load_i) begin
            m_cnt <= d_i; m_rel <= d_i; m_done <= 1'b0; m_uf <= 1'b0;
        end else if (en_i) begin
            if (m_cnt == 4'd0) begin
                m_uf <= 1'b1; m_done <= 1'b0;
                if (auto_i) m_cnt <= m_rel;
            end else begin
                m_uf <= 1'b0; m_done <= (m_cnt == 4'd1); m_cnt <= m_cnt - 4'd1;
            end
        end else begin
            m_done <= 1'b0; m_uf <= 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model cqo", int'(cqo), int'(m_cnt));
            chk("model tc", int'(tc_o), int'(m_cnt == 4'd0));
            chk("model done", int'(done_o), int'(m_done));
            chk("model uf", int'(uf_o), int'(m_uf));
        end
    end

    task automatic cyc(input logic ld, input logic [3:0] d, input logic en, input logic au);
        load_i = ld; d_i = d; en_i = en; auto_i = au;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input int c, input int dn, input int u);
        chk({name, " cqo"}, int'(cqo), c);
        chk({name, " tc"}, int'(tc_o), int'(c == 0));
        chk({name, " done"}, int'(done_o), dn);
        chk({name, " uf"}, int'(uf_o), u);
    endtask

    initial begin
        int seq3 [9];
        int dn3 [9];
        int uf3 [9];
        seq3 = '{1, 0, 2, 1, 0, 2, 1, 0, 2};
        dn3  = '{0, 1, 0, 0, 1, 0, 0, 1, 0};
        uf3  = '{0, 0, 1, 0, 0, 1, 0, 0, 1};

        #2;
        lit("reset", 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;

        // load 3, count down without reload
        cyc(1, 4'd3, 0, 0); lit("ld3", 3, 0, 0);
        cyc(0, 4'd0, 1, 0); lit("dn a", 2, 0, 0);
        cyc(0, 4'd0, 1, 0); lit("dn b", 1, 0, 0);
        cyc(0, 4'd0, 1, 0); lit("dn c", 0, 1, 0);
        cyc(0, 4'd0, 1, 0); lit("dn d", 0, 0, 1);
        cyc(0, 4'd0, 0, 0); lit("dn idle", 0, 0, 0);

        // periodic mode with reload 2
        cyc(1, 4'd2, 0, 1); lit("ld2", 2, 0, 0);
        for (int i = 0; i < 9; i++) begin
            cyc(0, 4'd0, 1, 1);
            lit($sformatf("per%0d", i), seq3[i], dn3[i], uf3[i]);
        end

        // hold at 15, then one decrement
        cyc(1, 4'd15, 0, 0); lit("ld15", 15, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 4'd0, 0, 1); lit("hold15", 15, 0, 0);
        end
        cyc(0, 4'd0, 1, 0); lit("dec14", 14, 0, 0);

        // load beats enable while at 1
        cyc(1, 4'd1, 0, 0); lit("ld1", 1, 0, 0);
        cyc(1, 4'd9, 1, 0); lit("ldwin", 9, 0, 0);

        // reload value of zero
        cyc(1, 4'd0, 0, 1); lit("ld0", 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 4'd0, 1, 1); lit("zero auto", 0, 0, 1);
        end

        // async reset mid-count at 5
        cyc(1, 4'd5, 0, 0); lit("ld5", 5, 0, 0);
        load_i = 1'b0; en_i = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        lit("async rst", 0, 0, 0);
        @(negedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        cyc(0, 4'd0, 1, 1); lit("rel lost", 0, 0, 1);

        // pseudo-random traffic checked against the model
        for (int i = 0; i < 60; i++) begin
            cyc(($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
                ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
